rv_imem_arb: RTL and testbench

//  Shares the single-port synchronous instruction SRAM between the IF-stage fetch port and a loader/debug port.
//  The loader port supports reads and byte-masked writes for boot load and debug.

---
 rtl/rv_pkg.sv | 16 +
 rtl/rv_arb_starve_cnt.sv | 36 +++
 rtl/rv_imem_arb.sv | 135 +++++++++++++
 tb/tb_rv_imem_arb.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Package shared by the instruction-memory arbiter slice.
//   RV_XLEN      : default data/address width
//   ARB_BE_ALL   : full-word byte enable used for every read
//   arb_owner_e  : owner of the read response pending for the next cycle
package rv_pkg;

    localparam int unsigned RV_XLEN    = 32;
    localparam logic [3:0]  ARB_BE_ALL = 4'hF;

    typedef enum logic [1:0] {
        ARB_OWN_NONE = 2'd0,
        ARB_OWN_IF   = 2'd1,
        ARB_OWN_LD   = 2'd2
    } arb_owner_e;

endpackage

// File: rtl/rv_arb_starve_cnt.sv
// Saturating 4-bit starvation counter for the fetch port.
// Ports:
//   i_cnt_clk     clock
//   i_cnt_rstn    asynchronous active-low reset
//   i_cnt_inc     increment (saturates at LIM)
//   i_cnt_clr     clear to zero (highest priority)
//   i_cnt_hold    freeze the current value (beats inc)
//   o_cnt_at_lim  count equals LIM
module rv_arb_starve_cnt #(
    parameter int unsigned LIM = 4
) (
    input  logic i_cnt_clk,
    input  logic i_cnt_rstn,
    input  logic i_cnt_inc,
    input  logic i_cnt_clr,
    input  logic i_cnt_hold,
    output logic o_cnt_at_lim
);

    localparam logic [3:0] LIM_V = 4'(LIM);

    logic [3:0] cnt_q;

    always_ff @(posedge i_cnt_clk or negedge i_cnt_rstn) begin
        if (!i_cnt_rstn) begin
            cnt_q <= '0;
        end else if (i_cnt_clr) begin
            cnt_q <= '0;
        end else if (!i_cnt_hold && i_cnt_inc && (cnt_q != LIM_V)) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign o_cnt_at_lim = (cnt_q == LIM_V);

endmodule

// File: rtl/rv_imem_arb.sv
// Arbiter sharing the single-port synchronous instruction SRAM between the
// IF-stage fetch port and the loader/debug port. Loader has priority; a
// starvation counter forces a fetch grant after STARVE_LIM denied cycles;
// a registered lock gives the loader exclusive access.
// Ports:
//   i_arb_clk / i_arb_rstn           clock, async active-low reset
//   i_arb_if_*  / o_arb_if_*         fetch request, grant, stall, response
//   i_arb_ld_*  / o_arb_ld_*         loader request/handshake, lock, response
//   o_arb_mem_* / i_arb_mem_rdata    SRAM command (word address) and read data
module rv_imem_arb
    import rv_pkg::*;
#(
    parameter int unsigned XLEN       = RV_XLEN,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic            i_arb_clk,
    input  logic            i_arb_rstn,
    input  logic            i_arb_if_req,
    input  logic [XLEN-1:0] i_arb_if_addr,
    output logic            o_arb_if_gnt,
    output logic            o_arb_if_stall,
    output logic            o_arb_if_rvalid,
    output logic [XLEN-1:0] o_arb_if_rdata,
    input  logic            i_arb_ld_valid,
    output logic            o_arb_ld_ready,
    input  logic            i_arb_ld_we,
    input  logic [XLEN-1:0] i_arb_ld_addr,
    input  logic [XLEN-1:0] i_arb_ld_wdata,
    input  logic [3:0]      i_arb_ld_be,
    input  logic            i_arb_ld_lock,
    output logic            o_arb_ld_rvalid,
    output logic [XLEN-1:0] o_arb_ld_rdata,
    output logic            o_arb_mem_en,
    output logic            o_arb_mem_we,
    output logic [3:0]      o_arb_mem_be,
    output logic [XLEN-1:0] o_arb_mem_addr,
    output logic [XLEN-1:0] o_arb_mem_wdata,
    input  logic [XLEN-1:0] i_arb_mem_rdata
);

    logic            lock_q;
    logic            at_lim;
    logic            force_if;
    logic            ld_ready;
    logic            if_gnt;
    logic            cnt_inc;
    logic            cnt_clr;
    logic [XLEN-1:0] sel_addr;
    logic [XLEN-1:0] if_rdata_q;
    logic [XLEN-1:0] ld_rdata_q;
    arb_owner_e      resp_q;
    arb_owner_e      resp_d;

    // Grant
    assign force_if = at_lim & ~lock_q;
    assign ld_ready = i_arb_ld_valid & ~force_if;
    assign if_gnt   = i_arb_if_req & ~ld_ready & ~lock_q;

    assign o_arb_ld_ready = ld_ready;
    assign o_arb_if_gnt   = if_gnt;
    assign o_arb_if_stall = i_arb_if_req & ~if_gnt;

    // Starvation: count denied fetch cycles; clearing during lock keeps the
    // count pinned at zero for the whole locked window.
    assign cnt_inc = i_arb_if_req & ~if_gnt & ~lock_q;
    assign cnt_clr = if_gnt | ~i_arb_if_req | lock_q;

    rv_arb_starve_cnt #(
        .LIM (STARVE_LIM)
    ) u_starve_cnt (
        .i_cnt_clk    (i_arb_clk),
        .i_cnt_rstn   (i_arb_rstn),
        .i_cnt_inc    (cnt_inc),
        .i_cnt_clr    (cnt_clr),
        .i_cnt_hold   (1'b0),
        .o_cnt_at_lim (at_lim)
    );

    // SRAM command mux
    always_comb begin
        o_arb_mem_en    = ld_ready | if_gnt;
        o_arb_mem_we    = 1'b0;
        o_arb_mem_be    = '0;
        o_arb_mem_wdata = '0;
        sel_addr        = '0;
        if (ld_ready) begin
            o_arb_mem_we    = i_arb_ld_we;
            o_arb_mem_be    = i_arb_ld_we ? i_arb_ld_be : ARB_BE_ALL;
            o_arb_mem_wdata = i_arb_ld_wdata;
            sel_addr        = i_arb_ld_addr;
        end else if (if_gnt) begin
            o_arb_mem_be    = ARB_BE_ALL;
            sel_addr        = i_arb_if_addr;
        end
    end

    // Byte address to word address; the low two bits are dropped.
    assign o_arb_mem_addr = sel_addr >> 2;

    // Response owner
    always_comb begin
        resp_d = ARB_OWN_NONE;
        if (ld_ready && !i_arb_ld_we) begin
            resp_d = ARB_OWN_LD;
        end else if (if_gnt) begin
            resp_d = ARB_OWN_IF;
        end
    end

    always_ff @(posedge i_arb_clk or negedge i_arb_rstn) begin
        if (!i_arb_rstn) begin
            lock_q     <= 1'b0;
            resp_q     <= ARB_OWN_NONE;
            if_rdata_q <= '0;
            ld_rdata_q <= '0;
        end else begin
            lock_q <= i_arb_ld_lock;
            resp_q <= resp_d;
            if (resp_q == ARB_OWN_IF) begin
                if_rdata_q <= i_arb_mem_rdata;
            end
            if (resp_q == ARB_OWN_LD) begin
                ld_rdata_q <= i_arb_mem_rdata;
            end
        end
    end

    // During a response cycle the SRAM data is passed straight through so it
    // lines up with rvalid; the registers hold it until the next response.
    assign o_arb_if_rvalid = (resp_q == ARB_OWN_IF);
    assign o_arb_ld_rvalid = (resp_q == ARB_OWN_LD);
    assign o_arb_if_rdata  = o_arb_if_rvalid ? i_arb_mem_rdata : if_rdata_q;
    assign o_arb_ld_rdata  = o_arb_ld_rvalid ? i_arb_mem_rdata : ld_rdata_q;

endmodule

// File: tb/tb_rv_imem_arb.sv
module tb_rv_imem_arb;

    logic        clk;
    logic        rstn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_stall;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ld_valid;
    logic        ld_ready;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic [3:0]  ld_be;
    logic        ld_lock;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] sram [0:63];
    int unsigned total;
    int unsigned bad;

    rv_imem_arb #(
        .XLEN       (32),
        .STARVE_LIM (4)
    ) dut (
        .i_arb_clk       (clk),
        .i_arb_rstn      (rstn),
        .i_arb_if_req    (if_req),
        .i_arb_if_addr   (if_addr),
        .o_arb_if_gnt    (if_gnt),
        .o_arb_if_stall  (if_stall),
        .o_arb_if_rvalid (if_rvalid),
        .o_arb_if_rdata  (if_rdata),
        .i_arb_ld_valid  (ld_valid),
        .o_arb_ld_ready  (ld_ready),
        .i_arb_ld_we     (ld_we),
        .i_arb_ld_addr   (ld_addr),
        .i_arb_ld_wdata  (ld_wdata),
        .i_arb_ld_be     (ld_be),
        .i_arb_ld_lock   (ld_lock),
        .o_arb_ld_rvalid (ld_rvalid),
        .o_arb_ld_rdata  (ld_rdata),
        .o_arb_mem_en    (mem_en),
        .o_arb_mem_we    (mem_we),
        .o_arb_mem_be    (mem_be),
        .o_arb_mem_addr  (mem_addr),
        .o_arb_mem_wdata (mem_wdata),
        .i_arb_mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port SRAM: word i initialised to 0x1000_0000 + i.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) sram[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= sram[mem_addr[5:0]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 64; i++) sram[i] = 32'h1000_0000 + i;
        mem_rdata = '0;
        rstn     = 1'b0;
        if_req   = 1'b1;
        if_addr  = '0;
        ld_valid = 1'b0;
        ld_we    = 1'b0;
        ld_addr  = '0;
        ld_wdata = '0;
        ld_be    = '0;
        ld_lock  = 1'b0;

        // Reset state; combinational grant follows inputs during reset
        #2;
        check("rst_if_rvalid", if_rvalid, 0);
        check("rst_ld_rvalid", ld_rvalid, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_ld_rdata", ld_rdata, 0);
        check("rst_if_gnt", if_gnt, 1);
        check("rst_mem_en", mem_en, 1);
        check("rst_ld_ready", ld_ready, 0);
        if_req = 1'b0;
        #20 rstn = 1'b1;

        // 1: fetch-only stream
        tick(); if_req = 1; if_addr = 32'h0; #1;
        check("t1_gnt", if_gnt, 1);
        check("t1_stall", if_stall, 0);
        check("t1_en", mem_en, 1);
        check("t1_we", mem_we, 0);
        check("t1_be", mem_be, 4'hF);
        check("t1_addr0", mem_addr, 0);
        tick(); if_addr = 32'h4; #1;
        check("t1_addr1", mem_addr, 1);
        check("t1_rv0", if_rvalid, 1);
        check("t1_rd0", if_rdata, 32'h1000_0000);
        tick(); if_addr = 32'h8; #1;
        check("t1_addr2", mem_addr, 2);
        check("t1_rd1", if_rdata, 32'h1000_0001);
        tick(); if_req = 0; #1;
        check("t1_rv2", if_rvalid, 1);
        check("t1_rd2", if_rdata, 32'h1000_0002);
        check("t1_idle_en", mem_en, 0);
        check("t1_idle_be", mem_be, 0);
        check("t1_idle_addr", mem_addr, 0);
        tick(); #1;
        check("t1_rv_off", if_rvalid, 0);
        check("t1_rd_hold", if_rdata, 32'h1000_0002);

        // 2: loader byte-masked write beats fetch
        tick(); if_req = 1; if_addr = 32'hC;
        ld_valid = 1; ld_we = 1; ld_addr = 32'h10; ld_wdata = 32'hDEAD_BEEF; ld_be = 4'b0011; #1;
        check("t2_ready", ld_ready, 1);
        check("t2_gnt", if_gnt, 0);
        check("t2_stall", if_stall, 1);
        check("t2_we", mem_we, 1);
        check("t2_be", mem_be, 4'b0011);
        check("t2_addr", mem_addr, 4);
        check("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick(); ld_valid = 0; ld_we = 0; #1;
        check("t2_gnt_after", if_gnt, 1);
        check("t2_stall_after", if_stall, 0);
        check("t2_addr_after", mem_addr, 3);
        check("t2_no_ld_rv", ld_rvalid, 0);
        check("t2_no_if_rv", if_rvalid, 0);
        tick(); if_req = 0; #1;
        check("t2_if_rv", if_rvalid, 1);
        check("t2_if_rd", if_rdata, 32'h1000_0003);
        check("t2_no_ld_rv2", ld_rvalid, 0);

        // 3: continuous loader vs fetch, starvation forces every 5th cycle
        for (int k = 0; k < 10; k++) begin
            tick(); if_req = 1; if_addr = 32'h40;
            ld_valid = 1; ld_we = 0; ld_addr = 32'h8; ld_be = 4'hF; #1;
            check($sformatf("t3_gnt_%0d", k), if_gnt, (k % 5 == 4));
            check($sformatf("t3_rdy_%0d", k), ld_ready, (k % 5 != 4));
        end
        tick(); if_req = 0; ld_valid = 0; #1;

        // 4a: lock for 10 cycles with fetch requesting
        for (int k = 0; k < 12; k++) begin
            tick(); if_req = 1; ld_lock = (k < 10); #1;
            check($sformatf("t4_gnt_%0d", k), if_gnt, (k == 0 || k == 11));
            check($sformatf("t4_stall_%0d", k), if_stall, !(k == 0 || k == 11));
        end
        tick(); if_req = 0; ld_lock = 0; #1;

        // 4b: lock discards partial starvation count
        for (int k = 0; k < 11; k++) begin
            tick(); if_req = 1; ld_valid = 1; ld_we = 0; ld_addr = 32'h8;
            ld_lock = (k >= 2 && k <= 4); #1;
            check($sformatf("t4b_gnt_%0d", k), if_gnt, (k == 10));
            check($sformatf("t4b_rdy_%0d", k), ld_ready, (k != 10));
        end
        tick(); if_req = 0; ld_valid = 0; #1;

        // 5: misaligned loader read of written word, loader read, then fetch read
        tick(); ld_valid = 1; ld_we = 0; ld_addr = 32'h12; ld_be = 4'hF; #1;
        check("t5_rdy", ld_ready, 1);
        check("t5_addr_mis", mem_addr, 4);
        check("t5_be_rd", mem_be, 4'hF);
        tick(); ld_addr = 32'h20; #1;
        check("t5_ld_rv0", ld_rvalid, 1);
        check("t5_ld_rd_mask", ld_rdata, 32'h1000_BEEF);
        check("t5_addr_ld", mem_addr, 8);
        tick(); ld_valid = 0; if_req = 1; if_addr = 32'h24; #1;
        check("t5_gnt", if_gnt, 1);
        check("t5_addr_if", mem_addr, 9);
        check("t5_ld_rv1", ld_rvalid, 1);
        check("t5_ld_rd", ld_rdata, 32'h1000_0008);
        check("t5_if_rv_early", if_rvalid, 0);
        tick(); if_req = 0; #1;
        check("t5_if_rv", if_rvalid, 1);
        check("t5_if_rd", if_rdata, 32'h1000_0009);
        check("t5_ld_rv_off", ld_rvalid, 0);
        check("t5_ld_rd_hold", ld_rdata, 32'h1000_0008);
        tick(); #1;
        check("t5_if_rv_off", if_rvalid, 0);
        check("t5_if_rd_hold", if_rdata, 32'h1000_0009);

        // 6: async reset in the response cycle after a fetch grant
        tick(); if_req = 1; if_addr = 32'h4; #1;
        check("t6_gnt", if_gnt, 1);
        tick(); if_req = 0; #1;
        rstn = 1'b0; #1;
        check("t6_if_rv", if_rvalid, 0);
        check("t6_if_rd", if_rdata, 0);
        check("t6_ld_rd", ld_rdata, 0);
        check("t6_ld_rv", ld_rvalid, 0);
        tick(); #1;
        check("t6_if_rv_hold", if_rvalid, 0);
        rstn = 1'b1;
        tick(); #1;
        check("t6_if_rv_post", if_rvalid, 0);
        check("t6_if_rd_post", if_rdata, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
